// File: rtl/booth_arb_pkg.sv
// Shared definitions for the Booth multiplier front-end arbiter:
// FSM state encoding used by booth_mul_arbiter and visible on its debug port.
package booth_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

endpackage

// File: rtl/booth_rr_picker.sv
// Round-robin picker: returns the first set req bit searching upward from
// (ptr+1) mod N_REQ, as a one-hot grant plus its binary index.
// Purely combinational; the caller owns the pointer register.
module booth_rr_picker #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx
);

    logic             hit;
    logic [IDX_W-1:0] pos;

    // Walk all requesters once, starting just after the last winner.
    always_comb begin
        hit   = 1'b0;
        grant = '0;
        idx   = '0;
        pos   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = IDX_W'((int'(ptr) + 1 + k) % N_REQ);
            if (!hit && req[pos]) begin
                hit        = 1'b1;
                grant[pos] = 1'b1;
                idx        = pos;
            end
        end
    end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter in front of a shared Booth multiplier core.
// One transaction at a time: IDLE (grant) -> ISSUE (start core) ->
// WAIT (core busy) -> RESP (return product to the granted requester).
// Optional feature macro: BOOTH_ARB_TIMEOUT_EN adds a WAIT watchdog that
// answers with rsp_prod=0, rsp_err=1 after TIMEOUT cycles without mul_done.
//
// Handshake: gnt[i] pulses for one cycle while IDLE picks requester i; the
// requester drops req[i] the cycle after. req is only looked at in IDLE.
// rsp_valid[i] pulses one cycle; rsp_prod/rsp_err are meaningful only then.
// mul_start pulses one cycle in ISSUE with mul_a/mul_b already stable;
// mul_done is sampled from the first WAIT cycle on, never in ISSUE.
module booth_mul_arbiter
    import booth_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [2*WIDTH-1:0]     rsp_prod,
    output logic                   rsp_err,
    output logic                   mul_start,
    output logic [WIDTH-1:0]       mul_a,
    output logic [WIDTH-1:0]       mul_b,
    input  logic                   mul_done,
    input  logic [2*WIDTH-1:0]     mul_prod,
    output state_t                 dbg_state
);

    localparam int IDX_W = $clog2(N_REQ);

    state_t           state;
    state_t           state_nx;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] pick_idx;
    logic [N_REQ-1:0] pick_grant;
    logic             any_req;
    logic             timed_out;
    logic             err_q;
    logic [WIDTH-1:0] a_slot [N_REQ];
    logic [WIDTH-1:0] b_slot [N_REQ];

    assign any_req   = |req;
    assign dbg_state = state;

    for (genvar i = 0; i < N_REQ; i++) begin : g_slot
        assign a_slot[i] = req_a[i*WIDTH +: WIDTH];
        assign b_slot[i] = req_b[i*WIDTH +: WIDTH];
    end

    booth_rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (req),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

`ifdef BOOTH_ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    logic [TMR_W-1:0] timer;

    // WAIT-cycle counter; restarts from zero on every entry into WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (state == ST_WAIT) begin
            timer <= timer + 1'b1;
        end else begin
            timer <= '0;
        end
    end

    // The last allowed WAIT cycle is timer == TIMEOUT-1; a late done still wins.
    assign timed_out = (state == ST_WAIT) && !mul_done &&
                       (timer == TMR_W'(TIMEOUT - 1));

    // Error flag for the pending response: set on watchdog expiry only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state == ST_WAIT) begin
            if (mul_done) begin
                err_q <= 1'b0;
            end else if (timed_out) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign timed_out = 1'b0;
    assign err_q     = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (any_req) state_nx = ST_ISSUE;
            ST_ISSUE: state_nx = ST_WAIT;
            ST_WAIT:  if (mul_done || timed_out) state_nx = ST_RESP;
            ST_RESP:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Pulse outputs decoded from state; gnt is forced low while rst is held.
    always_comb begin
        gnt       = '0;
        mul_start = 1'b0;
        rsp_valid = '0;
        rsp_err   = 1'b0;
        case (state)
            ST_IDLE:  if (!rst) gnt = pick_grant;
            ST_ISSUE: mul_start = 1'b1;
            ST_RESP: begin
                rsp_valid[sel] = 1'b1;
                rsp_err        = err_q;
            end
            default: ;
        endcase
    end

    // Operand capture, result capture and round-robin pointer update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= IDX_W'(N_REQ - 1);
            sel      <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
            rsp_prod <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        sel   <= pick_idx;
                        mul_a <= a_slot[pick_idx];
                        mul_b <= b_slot[pick_idx];
                    end
                end
                ST_WAIT: begin
                    if (mul_done) begin
                        rsp_prod <= mul_prod;
                    end else if (timed_out) begin
                        rsp_prod <= '0;
                    end
                end
                ST_RESP: ptr <= sel;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed bench for booth_mul_arbiter with a behavioural multiplier core.
// Define BOOTH_ARB_TIMEOUT_EN on both RTL and bench to exercise the watchdog.
module tb_booth_mul_arbiter;
  import booth_arb_pkg::*;

  localparam int TB_TIMEOUT = 64;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  gnt;
  logic [3:0]  rsp_valid;
  logic [15:0] rsp_prod;
  logic        rsp_err;
  logic        mul_start;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic        mul_done;
  logic [15:0] mul_prod;
  state_t      dbg_state;

  booth_mul_arbiter #(
    .N_REQ   (4),
    .WIDTH   (8),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_a     (req_a),
    .req_b     (req_b),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_prod  (rsp_prod),
    .rsp_err   (rsp_err),
    .mul_start (mul_start),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_done  (mul_done),
    .mul_prod  (mul_prod),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // behavioural core: latency core_lat after start, one-cycle done pulse
  int                 core_lat;
  logic               core_stuck;
  logic               core_busy;
  int                 core_cnt;
  logic signed [15:0] core_pa;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_busy <= 1'b0;
      core_cnt  <= 0;
      core_pa   <= '0;
      mul_done  <= 1'b0;
      mul_prod  <= '0;
    end else begin
      mul_done <= 1'b0;
      if (mul_start) begin
        core_busy <= 1'b1;
        core_cnt  <= core_lat;
        core_pa   <= $signed(mul_a) * $signed(mul_b);
      end else if (core_busy && !core_stuck) begin
        if (core_cnt == 0) begin
          core_busy <= 1'b0;
          mul_done  <= 1'b1;
          mul_prod  <= core_pa;
        end else begin
          core_cnt <= core_cnt - 1;
        end
      end
    end
  end

  // scoreboard state
  int         checks;
  int         errors;
  int         cyc;
  logic       auto_drop;
  logic [3:0] drop_pend;
  logic [3:0] gnt_log[$];
  int         gnt_cyc_log[$];
  logic [3:0] rsp_v_log[$];
  logic [15:0] rsp_p_log[$];
  logic       rsp_e_log[$];
  int         rsp_cyc_log[$];
  int         start_cnt;
  int         start_cyc;
  logic [7:0] start_a;
  logic [7:0] start_b;

  task automatic clear_logs();
    gnt_log.delete();
    gnt_cyc_log.delete();
    rsp_v_log.delete();
    rsp_p_log.delete();
    rsp_e_log.delete();
    rsp_cyc_log.delete();
    start_cnt = 0;
    start_cyc = -1;
  endtask

  // one clock: sample at negedge, then return 1ns after the next posedge
  task automatic step();
    logic [3:0] g;
    @(negedge clk);
    cyc++;
    g = '0;
    if (!rst) begin
      g = gnt;
      if (gnt != 4'b0000) begin
        gnt_log.push_back(gnt);
        gnt_cyc_log.push_back(cyc);
        checks++;
        if (!$onehot(gnt)) begin
          errors++;
          $display("FAIL gnt_onehot: gnt=%b, required one-hot", gnt);
        end
      end
      if (rsp_valid != 4'b0000) begin
        rsp_v_log.push_back(rsp_valid);
        rsp_p_log.push_back(rsp_prod);
        rsp_e_log.push_back(rsp_err);
        rsp_cyc_log.push_back(cyc);
      end
      if (mul_start) begin
        start_cnt++;
        start_cyc = cyc;
        start_a   = mul_a;
        start_b   = mul_b;
      end
    end
    @(posedge clk);
    #1;
    if (auto_drop) req = req & ~drop_pend;
    drop_pend = g;
  endtask

  task automatic set_slot(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req       = '0;
    drop_pend = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic run_until_rsp(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (rsp_v_log.size() < n && k < budget) begin
      step();
      k++;
    end
    checks++;
    if (rsp_v_log.size() < n) begin
      errors++;
      $display("FAIL %s_wait: got %0d responses, required %0d", tag, rsp_v_log.size(), n);
    end
  endtask

  task automatic wait_gnt(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (gnt_log.size() < n && k < budget) begin
      step();
      k++;
    end
    checks++;
    if (gnt_log.size() < n) begin
      errors++;
      $display("FAIL %s_gnt_wait: got %0d grants, required %0d", tag, gnt_log.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    step();
    checks++;
    if ({gnt, rsp_valid, rsp_err, mul_start} !== 10'b0) begin
      errors++;
      $display("FAIL reset_pulses: gnt=%b rsp_valid=%b rsp_err=%b mul_start=%b, required 0",
               gnt, rsp_valid, rsp_err, mul_start);
    end
    checks++;
    if ({rsp_prod, mul_a, mul_b} !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: rsp_prod=%h mul_a=%h mul_b=%h, required 0", rsp_prod, mul_a, mul_b);
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: state=%0d, required %0d", dbg_state, ST_IDLE);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    clear_logs();
    auto_drop = 1'b1;
    set_slot(0, 8'd3, 8'hFB);
    req = 4'b0001;
    run_until_rsp(1, 40, "single");
    checks++;
    if (gnt_log.size() !== 1 || gnt_log[0] !== 4'b0001) begin
      errors++;
      $display("FAIL single_gnt: %0d grants first=%b, required 1 grant 0001", gnt_log.size(), gnt_log[0]);
    end
    checks++;
    if (start_cnt !== 1) begin
      errors++;
      $display("FAIL single_start_count: got %0d, required 1", start_cnt);
    end
    checks++;
    if (start_cyc !== gnt_cyc_log[0] + 1) begin
      errors++;
      $display("FAIL single_start_latency: start cycle %0d, required %0d", start_cyc, gnt_cyc_log[0] + 1);
    end
    checks++;
    if ({start_a, start_b} !== 16'h03FB) begin
      errors++;
      $display("FAIL single_operands: a=%h b=%h, required 03 FB", start_a, start_b);
    end
    checks++;
    if (rsp_v_log[0] !== 4'b0001 || rsp_p_log[0] !== 16'hFFF1 || rsp_e_log[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_rsp: valid=%b prod=%h err=%b, required 0001 FFF1 0",
               rsp_v_log[0], rsp_p_log[0], rsp_e_log[0]);
    end
    // core model answers two cycles after start; response follows one later
    checks++;
    if (rsp_cyc_log[0] !== start_cyc + 3) begin
      errors++;
      $display("FAIL single_rsp_latency: rsp cycle %0d, required %0d", rsp_cyc_log[0], start_cyc + 3);
    end
    step();
    step();
    step();
    checks++;
    if (rsp_valid !== 4'b0000 || rsp_prod !== 16'hFFF1) begin
      errors++;
      $display("FAIL single_hold: rsp_valid=%b rsp_prod=%h, required 0000 FFF1", rsp_valid, rsp_prod);
    end
  endtask

  task automatic test_extremes();
    clear_logs();
    set_slot(1, 8'h80, 8'h80);
    req = 4'b0010;
    run_until_rsp(1, 40, "ext_neg");
    checks++;
    if (rsp_v_log[0] !== 4'b0010 || rsp_p_log[0] !== 16'h4000) begin
      errors++;
      $display("FAIL ext_neg_neg: valid=%b prod=%h, required 0010 4000", rsp_v_log[0], rsp_p_log[0]);
    end
    step();
    clear_logs();
    set_slot(3, 8'h7F, 8'h80);
    req = 4'b1000;
    run_until_rsp(1, 40, "ext_mix");
    checks++;
    if (rsp_v_log[0] !== 4'b1000 || rsp_p_log[0] !== 16'hC080) begin
      errors++;
      $display("FAIL ext_pos_neg: valid=%b prod=%h, required 1000 C080", rsp_v_log[0], rsp_p_log[0]);
    end
    step();
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_g[5];
    logic [15:0] exp_p[5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_p = '{16'h0006, 16'hFFEC, 16'hFFCF, 16'h0001, 16'h0006};
    do_reset();
    clear_logs();
    auto_drop = 1'b0;
    set_slot(0, 8'd2, 8'd3);
    set_slot(1, 8'hFC, 8'd5);
    set_slot(2, 8'd7, 8'hF9);
    set_slot(3, 8'hFF, 8'hFF);
    req = 4'b1111;
    run_until_rsp(5, 200, "rr");
    req = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (gnt_log[i] !== exp_g[i] || rsp_v_log[i] !== exp_g[i] || rsp_p_log[i] !== exp_p[i]) begin
        errors++;
        $display("FAIL rr_order_%0d: gnt=%b valid=%b prod=%h, required %b %b %h",
                 i, gnt_log[i], rsp_v_log[i], rsp_p_log[i], exp_g[i], exp_g[i], exp_p[i]);
      end
    end
    step();
    step();
    auto_drop = 1'b1;
  endtask

  task automatic test_back_to_back();
    do_reset();
    clear_logs();
    core_lat = 4;
    set_slot(1, 8'd5, 8'd6);
    req = 4'b0010;
    wait_gnt(1, 20, "late");
    step();
    checks++;
    if (dbg_state !== ST_WAIT) begin
      errors++;
      $display("FAIL late_in_wait: state=%0d, required %0d", dbg_state, ST_WAIT);
    end
    set_slot(2, 8'hFE, 8'hFD);
    req[2] = 1'b1;
    run_until_rsp(2, 60, "late");
    checks++;
    if (gnt_log.size() !== 2 || gnt_log[0] !== 4'b0010 || gnt_log[1] !== 4'b0100) begin
      errors++;
      $display("FAIL late_gnt_seq: %0d grants %b %b, required 0010 0100", gnt_log.size(), gnt_log[0], gnt_log[1]);
    end
    checks++;
    if (gnt_cyc_log[1] !== rsp_cyc_log[0] + 1) begin
      errors++;
      $display("FAIL late_gnt_after_resp: gnt2 cycle %0d, required %0d", gnt_cyc_log[1], rsp_cyc_log[0] + 1);
    end
    checks++;
    if (rsp_v_log[0] !== 4'b0010 || rsp_p_log[0] !== 16'h001E ||
        rsp_v_log[1] !== 4'b0100 || rsp_p_log[1] !== 16'h0006) begin
      errors++;
      $display("FAIL late_rsp: %b/%h %b/%h, required 0010/001E 0100/0006",
               rsp_v_log[0], rsp_p_log[0], rsp_v_log[1], rsp_p_log[1]);
    end
    step();
  endtask

  task automatic test_reset_mid();
    logic [3:0]  exp_g[4];
    logic [15:0] exp_p[4];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_p = '{16'h0064, 16'hFFF4, 16'h0000, 16'h3F01};
    clear_logs();
    core_lat = 8;
    set_slot(0, 8'd9, 8'd9);
    req = 4'b0001;
    wait_gnt(1, 20, "rstmid");
    step();
    checks++;
    if (dbg_state !== ST_WAIT || rsp_prod !== 16'h0006) begin
      errors++;
      $display("FAIL rstmid_pre: state=%0d rsp_prod=%h, required %0d 0006", dbg_state, rsp_prod, ST_WAIT);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({gnt, rsp_valid, rsp_err, mul_start, rsp_prod, mul_a, mul_b} !== 42'h0) begin
      errors++;
      $display("FAIL rstmid_clear: gnt=%b valid=%b err=%b start=%b prod=%h a=%h b=%h, required all 0",
               gnt, rsp_valid, rsp_err, mul_start, rsp_prod, mul_a, mul_b);
    end
    req       = '0;
    drop_pend = '0;
    step();
    step();
    rst = 1'b0;
    clear_logs();
    core_lat = 1;
    set_slot(0, 8'd10, 8'd10);
    set_slot(1, 8'hFD, 8'd4);
    set_slot(2, 8'd0, 8'h80);
    set_slot(3, 8'h7F, 8'h7F);
    req = 4'b1111;
    run_until_rsp(4, 200, "rstmid");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (gnt_log[i] !== exp_g[i] || rsp_v_log[i] !== exp_g[i] || rsp_p_log[i] !== exp_p[i]) begin
        errors++;
        $display("FAIL rstmid_after_%0d: gnt=%b valid=%b prod=%h, required %b %b %h",
                 i, gnt_log[i], rsp_v_log[i], rsp_p_log[i], exp_g[i], exp_g[i], exp_p[i]);
      end
    end
    step();
    step();
    checks++;
    if (rsp_v_log.size() !== 4) begin
      errors++;
      $display("FAIL rstmid_rsp_count: got %0d, required 4", rsp_v_log.size());
    end
  endtask

`ifdef BOOTH_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    clear_logs();
    core_stuck = 1'b1;
    set_slot(0, 8'd4, 8'd4);
    req = 4'b0001;
    run_until_rsp(1, TB_TIMEOUT + 30, "tmo");
    checks++;
    if (rsp_v_log[0] !== 4'b0001 || rsp_e_log[0] !== 1'b1 || rsp_p_log[0] !== 16'h0000) begin
      errors++;
      $display("FAIL tmo_rsp: valid=%b err=%b prod=%h, required 0001 1 0000",
               rsp_v_log[0], rsp_e_log[0], rsp_p_log[0]);
    end
    checks++;
    if (rsp_cyc_log[0] !== start_cyc + 1 + TB_TIMEOUT) begin
      errors++;
      $display("FAIL tmo_latency: rsp cycle %0d, required %0d", rsp_cyc_log[0], start_cyc + 1 + TB_TIMEOUT);
    end
    core_stuck = 1'b0;
    step();
  endtask
`endif

  initial begin
    checks     = 0;
    errors     = 0;
    cyc        = 0;
    rst        = 1'b1;
    req        = '0;
    req_a      = '0;
    req_b      = '0;
    auto_drop  = 1'b1;
    drop_pend  = '0;
    core_lat   = 0;
    core_stuck = 1'b0;
    clear_logs();
    test_reset();
    test_single();
    test_extremes();
    test_round_robin();
    test_back_to_back();
    test_reset_mid();
`ifdef BOOTH_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
